// File: rtl/debug_unit_pkg.sv
// rtl/debug_unit_pkg.sv - shared state encoding and command bytes for the debug unit
package debug_unit_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WRITE,
    MODE,
    RUN,
    STEP_WAIT,
    STEP,
    SEND,
    DONE
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC000000;

endpackage

// File: rtl/debug_unit_if.sv
// rtl/debug_unit_if.sv - UART byte streams, instruction-load bus and pipeline control
interface debug_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;
  logic [DATA_WIDTH-1:0] o_instruccion;
  logic [DATA_WIDTH-1:0] o_address;
  logic                  o_loading;
  logic                  o_start;
  logic                  o_step;
  logic                  i_finish;
  logic [DATA_WIDTH-1:0] i_result_wb;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_finish, i_result_wb,
    output o_tx_data, o_tx_valid, o_instruccion, o_address, o_loading, o_start, o_step
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_finish, i_result_wb,
    input  o_tx_data, o_tx_valid, o_instruccion, o_address, o_loading, o_start, o_step
  );

endinterface

// File: rtl/debug_unit_tx_serializer.sv
// rtl/debug_unit_tx_serializer.sv - captures a 32-bit word and sends it MSB byte first
module debug_tx_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] shreg;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg    <= word;
        byte_cnt <= '0;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        // The next byte is exposed by the shift, so it appears the cycle after acceptance.
        if (byte_cnt == 2'd3) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          shreg    <= {shreg[23:0], 8'h00};
        end
      end
    end
  end

  assign tx_data = shreg[31:24];

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART-driven loader and run/step controller for the pipeline
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MAX_INSTR  = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(HALT_WORD_DEFAULT)
) (
  input  logic         i_clock,
  input  logic         i_reset,
  debug_unit_if.master bus
);

  localparam int CNT_W = $clog2(MAX_INSTR + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_INSTR - 1);

  state_t                state;
  logic [1:0]            byte_cnt;
  logic [CNT_W-1:0]      word_cnt;
  logic [DATA_WIDTH-1:0] shift_word;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  loading_q;
  logic                  start_q;
  logic                  step_q;
  logic                  from_run;
  logic                  tx_start;
  logic                  tx_done;
  logic [7:0]            tx_data;
  logic                  tx_valid;

  logic [DATA_WIDTH-1:0] next_word;
  logic                  rx_load;
  logic                  rx_cont;
  logic                  rx_step;
  logic                  rx_next;

  assign next_word = {shift_word[DATA_WIDTH-9:0], bus.i_rx_data};
  assign rx_load   = bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD);
  assign rx_cont   = bus.i_rx_valid && (bus.i_rx_data == CMD_CONT);
  assign rx_step   = bus.i_rx_valid && (bus.i_rx_data == CMD_STEP);
  assign rx_next   = bus.i_rx_valid && (bus.i_rx_data == CMD_NEXT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      shift_word <= '0;
      addr       <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      loading_q  <= 1'b0;
      start_q    <= 1'b0;
      step_q     <= 1'b0;
      from_run   <= 1'b0;
      tx_start   <= 1'b0;
    end else begin
      loading_q <= 1'b0;
      step_q    <= 1'b0;
      tx_start  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (rx_load) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_cnt <= '0;
            addr     <= '0;
          end
        end
        LOAD: begin
          if (bus.i_rx_valid) begin
            shift_word <= next_word;
            byte_cnt   <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= WRITE;
              loading_q <= 1'b1;
              instr_q   <= next_word;
              addr_q    <= addr;
            end
          end
        end
        WRITE: begin
          addr     <= addr + DATA_WIDTH'(4);
          word_cnt <= word_cnt + 1'b1;
          byte_cnt <= '0;
          // The halt word has already been written this cycle; stop here or when memory is full.
          if (instr_q == HALT_WORD || word_cnt == LAST_CNT) state <= MODE;
          else                                              state <= LOAD;
        end
        MODE: begin
          if (rx_cont) begin
            state    <= RUN;
            start_q  <= 1'b1;
            from_run <= 1'b1;
          end else if (rx_step) begin
            state    <= STEP_WAIT;
            from_run <= 1'b0;
          end
        end
        RUN: begin
          if (bus.i_finish) begin
            start_q  <= 1'b0;
            state    <= SEND;
            tx_start <= 1'b1;
          end
        end
        STEP_WAIT: begin
          if (bus.i_finish) begin
            state    <= SEND;
            tx_start <= 1'b1;
          end else if (rx_next) begin
            state  <= STEP;
            step_q <= 1'b1;
          end
        end
        STEP: begin
          state    <= SEND;
          tx_start <= 1'b1;
        end
        SEND: begin
          if (tx_done) state <= (from_run || bus.i_finish) ? DONE : STEP_WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  debug_tx_serializer u_tx (
    .clk      (i_clock),
    .reset    (i_reset),
    .start    (tx_start),
    .word     (32'(bus.i_result_wb)),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (bus.i_tx_ready),
    .done     (tx_done)
  );

  assign bus.o_tx_data     = tx_data;
  assign bus.o_tx_valid    = tx_valid;
  assign bus.o_instruccion = instr_q;
  assign bus.o_address     = addr_q;
  assign bus.o_loading     = loading_q;
  assign bus.o_start       = start_q;
  assign bus.o_step        = step_q;

endmodule
